// File: rtl/generator_consumer.sv
// Generator-to-host bridge: runs one generator pass per _go and buffers yielded tuples in a FIFO.
// Optional watchdog on the RUN state is enabled by defining GEN_CONSUMER_TIMEOUT_EN.
module generator_consumer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                      _clock,
    input  logic                      _reset_n,
    input  logic                      _go,
    output logic                      _busy,
    output logic                      gen_start,
    input  logic                      gen_valid,
    input  logic signed [WIDTH-1:0]   gen_out0,
    input  logic signed [WIDTH-1:0]   gen_out1,
    input  logic                      gen_done,
    input  logic                      _ready,
    output logic                      _valid,
    output logic signed [WIDTH-1:0]   _out0,
    output logic signed [WIDTH-1:0]   _out1,
    output logic [$clog2(DEPTH):0]    _count,
    output logic                      _overflow,
    output logic                      _timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic signed [WIDTH-1:0] mem0 [DEPTH];
    logic signed [WIDTH-1:0] mem1 [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ovf_flag;
    logic          full, push_req, push, pop, drop, launch, tmo_fire;

    assign full     = (count == FULL_COUNT);
    assign push_req = (state == RUN) && gen_valid && !gen_done;
    assign pop      = _valid && _ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign launch   = (state == IDLE) && _go;

`ifdef GEN_CONSUMER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_flag;

    always_ff @(posedge _clock) begin
        if (!_reset_n) begin
            tmo_cnt <= '0;
        end else if (state == START) begin
            tmo_cnt <= '0;
        end else if (state == RUN) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_fire = (state == RUN) && !gen_done && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge _clock) begin
        if (!_reset_n)     tmo_flag <= 1'b0;
        else if (launch)   tmo_flag <= 1'b0;
        else if (tmo_fire) tmo_flag <= 1'b1;
    end

    assign _timeout = tmo_flag;
`else
    assign tmo_fire = 1'b0;
    assign _timeout = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge _clock) begin
        if (!_reset_n) state <= IDLE;
        else           state <= state_next;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (_go) state_next = START;
            START:   state_next = RUN;
            RUN:     if (gen_done || tmo_fire) state_next = DRAIN;
            DRAIN:   if (count == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: storage has no reset; occupancy and pointers alone decide what is readable.
    always_ff @(posedge _clock) begin
        if (push) begin
            mem0[wr_ptr] <= gen_out0;
            mem1[wr_ptr] <= gen_out1;
        end
    end

    always_ff @(posedge _clock) begin
        if (!_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge _clock) begin
        if (!_reset_n)   ovf_flag <= 1'b0;
        else if (launch) ovf_flag <= 1'b0;
        else if (drop)   ovf_flag <= 1'b1;
    end

    assign _busy     = (state != IDLE);
    assign gen_start = (state == START);
    assign _valid    = (count != '0);
    assign _count    = count;
    assign _overflow = ovf_flag;
    // The head is forced to zero when empty so stale storage never shows after reset.
    assign _out0     = _valid ? mem0[rd_ptr] : '0;
    assign _out1     = _valid ? mem1[rd_ptr] : '0;

endmodule

// File: tb/tb_generator_consumer.sv
// Scoreboard bench for generator_consumer: a cycle model predicts FIFO contents and flags,
// and a negedge monitor compares DUT outputs and popped tuples against it.
module tb_generator_consumer;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    go;
    logic                    busy;
    logic                    gen_start;
    logic                    gen_valid;
    logic signed [WIDTH-1:0] gen_out0;
    logic signed [WIDTH-1:0] gen_out1;
    logic                    gen_done;
    logic                    ready;
    logic                    valid;
    logic signed [WIDTH-1:0] out0;
    logic signed [WIDTH-1:0] out1;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;
    logic                    timeout;

    always #5 clk = ~clk;

    generator_consumer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        ._clock   (clk),
        ._reset_n (rst_n),
        ._go      (go),
        ._busy    (busy),
        .gen_start(gen_start),
        .gen_valid(gen_valid),
        .gen_out0 (gen_out0),
        .gen_out1 (gen_out1),
        .gen_done (gen_done),
        ._ready   (ready),
        ._valid   (valid),
        ._out0    (out0),
        ._out1    (out1),
        ._count   (count),
        ._overflow(overflow),
        ._timeout (timeout)
    );

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } tuple_t;

    typedef enum {M_IDLE, M_START, M_RUN, M_DRAIN} mstate_t;

    tuple_t  sb[$];
    tuple_t  got_q[$];
    mstate_t m_state = M_IDLE;
    int      m_run   = 0;
    int      m_occ;
    bit      m_pop, m_push;
    bit      m_ovf   = 1'b0;
    bit      m_tmo   = 1'b0;
    bit      mon_en  = 1'b0;
    int      n_start = 0;
    int      n_checks = 0;
    int      n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: advances on each rising edge from the inputs the bench drove.
    always @(posedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_state = M_IDLE;
            m_ovf   = 1'b0;
            m_tmo   = 1'b0;
            m_run   = 0;
        end else begin
            m_occ  = sb.size();
            m_pop  = (m_occ != 0) && ready;
            m_push = (m_state == M_RUN) && gen_valid && !gen_done;
            if (m_pop) void'(sb.pop_front());
            if (m_push) begin
                if (m_occ < DEPTH || m_pop) sb.push_back(tuple_t'{gen_out0, gen_out1});
                else                        m_ovf = 1'b1;
            end
            case (m_state)
                M_IDLE: if (go) begin
                    m_state = M_START;
                    m_ovf   = 1'b0;
                    m_tmo   = 1'b0;
                end
                M_START: begin
                    m_state = M_RUN;
                    m_run   = 0;
                end
                M_RUN: begin
                    m_run++;
                    if (gen_done) m_state = M_DRAIN;
`ifdef GEN_CONSUMER_TIMEOUT_EN
                    else if (m_run == TIMEOUT) begin
                        m_state = M_DRAIN;
                        m_tmo   = 1'b1;
                    end
`endif
                end
                M_DRAIN: if (m_occ == 0) m_state = M_IDLE;
                default: m_state = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("count", 64'(count), 64'(sb.size()));
            check("valid", 64'(valid), 64'(sb.size() != 0));
            check("busy", 64'(busy), 64'(m_state != M_IDLE));
            check("gen_start", 64'(gen_start), 64'(m_state == M_START));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("timeout", 64'(timeout), 64'(m_tmo));
            if (gen_start) n_start++;
            if (sb.size() != 0 && ready && rst_n) begin
                check("head_out0", 64'($unsigned(out0)), 64'(sb[0].a));
                check("head_out1", 64'($unsigned(out1)), 64'(sb[0].b));
                got_q.push_back(tuple_t'{out0, out1});
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the DUT in RUN; a junk tuple offered during START must be ignored.
    task automatic pass_begin();
        go = 1'b1;
        cyc();
        go        = 1'b0;
        gen_valid = 1'b1;
        gen_out0  = 32'sd999;
        gen_out1  = 32'sd999;
        cyc();
        gen_valid = 1'b0;
    endtask

    task automatic yield(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
        gen_valid = 1'b1;
        gen_out0  = a;
        gen_out1  = b;
        cyc();
        gen_valid = 1'b0;
    endtask

    // gen_valid rides along with gen_done to confirm it is not pushed.
    task automatic finish_gen();
        gen_done  = 1'b1;
        gen_valid = 1'b1;
        gen_out0  = 32'sd777;
        gen_out1  = 32'sd777;
        cyc();
        gen_done  = 1'b0;
        gen_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            cyc();
            k++;
        end
        check("idle_within_budget", 64'(k < budget), 64'd1);
    endtask

    initial begin
        int s0;
        rst_n = 1'b0; go = 1'b0; gen_valid = 1'b0; gen_done = 1'b0;
        gen_out0 = '0; gen_out1 = '0; ready = 1'b0;
        cyc();
        mon_en = 1'b1;
        cyc();
        check("rst_count", 64'(count), 64'd0);
        check("rst_out0", 64'($unsigned(out0)), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Basic pass, with _go re-asserted during RUN.
        ready = 1'b1;
        got_q.delete();
        s0 = n_start;
        pass_begin();
        go = 1'b1;
        yield(32'sd1, 32'sd2);
        go = 1'b0;
        yield(32'sd3, 32'sd4);
        finish_gen();
        wait_idle(20);
        check("basic_start_pulses", 64'(n_start - s0), 64'd1);
        check("basic_pops", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            check("basic_first", 64'(got_q[0]), {32'd1, 32'd2});
            check("basic_second", 64'(got_q[1]), {32'd3, 32'd4});
        end

        // Overflow: nine yields into an eight-deep FIFO with the host stalled.
        ready = 1'b0;
        pass_begin();
        for (int i = 0; i < 9; i++) yield(32'(i + 10), 32'(i + 20));
        finish_gen();
        check("ovf_count", 64'(count), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        got_q.delete();
        ready = 1'b1;
        wait_idle(20);
        check("ovf_pops", 64'(got_q.size()), 64'd8);
        if (got_q.size() == 8) check("ovf_last", 64'(got_q[7]), {32'd17, 32'd27});
        check("ovf_sticky_idle", 64'(overflow), 64'd1);

        // Full FIFO with simultaneous push and pop; also clears the old overflow on launch.
        ready = 1'b0;
        pass_begin();
        check("ovf_cleared_on_start", 64'(overflow), 64'd0);
        for (int i = 0; i < 8; i++) yield(32'(i + 40), 32'(i + 50));
        check("full_count", 64'(count), 64'd8);
        ready = 1'b1;
        yield(32'sd48, 32'sd58);
        ready = 1'b0;
        check("full_pushpop_count", 64'(count), 64'd8);
        check("full_pushpop_ovf", 64'(overflow), 64'd0);
        finish_gen();
        ready = 1'b1;
        wait_idle(20);

        // Reset in the middle of RUN with entries held.
        ready = 1'b0;
        pass_begin();
        for (int i = 0; i < 3; i++) yield(32'(i + 70), 32'(i + 80));
        check("midrun_count", 64'(count), 64'd3);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("midrun_rst_count", 64'(count), 64'd0);
        check("midrun_rst_valid", 64'(valid), 64'd0);
        check("midrun_rst_busy", 64'(busy), 64'd0);
        check("midrun_rst_start", 64'(gen_start), 64'd0);
        check("midrun_rst_out1", 64'($unsigned(out1)), 64'd0);
        cyc();

        // Watchdog: gen_done held low.
        ready = 1'b1;
        pass_begin();
        cyc(20);
`ifdef GEN_CONSUMER_TIMEOUT_EN
        check("tmo_flag", 64'(timeout), 64'd1);
        check("tmo_idle", 64'(busy), 64'd0);
`else
        check("tmo_flag", 64'(timeout), 64'd0);
        check("tmo_still_run", 64'(busy), 64'd1);
        finish_gen();
        wait_idle(20);
`endif

        // Random traffic to wrap the pointers several times.
        pass_begin();
        for (int i = 0; i < 40; i++) begin
            gen_valid = 1'($urandom_range(0, 1));
            gen_out0  = $signed($urandom());
            gen_out1  = $signed($urandom());
            ready     = 1'($urandom_range(0, 1));
            cyc();
        end
        gen_valid = 1'b0;
        finish_gen();
        ready = 1'b1;
        wait_idle(30);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1);
    end

endmodule
